// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: op encodings, bus types, reset level,
// FSM state encoding and small op-decode helpers.
package mem_stage_pkg;

  typedef logic [7:0]  alu_op_bus_t;
  typedef logic [31:0] reg_bus_t;
  typedef logic [4:0]  reg_addr_bus_t;

  localparam reg_bus_t ZERO_WORD  = 32'h0000_0000;
  localparam logic     RST_ENABLE = 1'b0;

  localparam alu_op_bus_t ME_NOP_OP = 8'h00;
  localparam alu_op_bus_t ME_LB     = 8'h01;
  localparam alu_op_bus_t ME_LH     = 8'h02;
  localparam alu_op_bus_t ME_LW     = 8'h03;
  localparam alu_op_bus_t ME_LBU    = 8'h04;
  localparam alu_op_bus_t ME_LHU    = 8'h05;
  localparam alu_op_bus_t ME_SB     = 8'h06;
  localparam alu_op_bus_t ME_SH     = 8'h07;
  localparam alu_op_bus_t ME_SW     = 8'h08;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  function automatic logic is_load(input alu_op_bus_t op);
    return (op == ME_LB) || (op == ME_LBU) || (op == ME_LH) ||
           (op == ME_LHU) || (op == ME_LW);
  endfunction

  function automatic logic is_store(input alu_op_bus_t op);
    return (op == ME_SB) || (op == ME_SH) || (op == ME_SW);
  endfunction

  function automatic logic is_mem(input alu_op_bus_t op);
    return is_load(op) || is_store(op);
  endfunction

  // Index of the final byte of the access (byte count minus one).
  function automatic logic [1:0] last_byte(input alu_op_bus_t op);
    case (op)
      ME_LH, ME_LHU, ME_SH: return 2'd1;
      ME_LW, ME_SW:         return 2'd3;
      default:              return 2'd0;
    endcase
  endfunction

  function automatic logic misaligned(input alu_op_bus_t op, input logic [1:0] addr);
    return ((op == ME_LH || op == ME_LHU || op == ME_SH) && addr[0]) ||
           ((op == ME_LW || op == ME_SW) && (addr != 2'b00));
  endfunction

endpackage

// File: rtl/mem_stage_load_ext.sv
// Combinational load formatter: picks the loaded bytes and sign/zero-extends
// them to 32 bits according to the load op.
module mem_load_ext
  import mem_stage_pkg::*;
(
  input  logic [3:0][7:0] bytes,
  input  alu_op_bus_t     op,
  output reg_bus_t        value
);

  always_comb begin
    value = ZERO_WORD;
    case (op)
      ME_LB:   value = {{24{bytes[0][7]}}, bytes[0]};
      ME_LBU:  value = {24'h000000, bytes[0]};
      ME_LH:   value = {{16{bytes[1][7]}}, bytes[1], bytes[0]};
      ME_LHU:  value = {16'h0000, bytes[1], bytes[0]};
      ME_LW:   value = {bytes[3], bytes[2], bytes[1], bytes[0]};
      default: value = ZERO_WORD;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: passes ALU results through and runs loads/stores byte-serially,
// little-endian, over a request/ack RAM port. Optional: MEM_ALIGN_CHECK_EN.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  reg_addr_bus_t     wd_i,
  input  logic              wreg_i,
  input  reg_bus_t          wdata_i,
  input  alu_op_bus_t       aluop_i,
  input  reg_bus_t          mem_addr_i,
  output reg_addr_bus_t     wd_o,
  output logic              wreg_o,
  output reg_bus_t          wdata_o,
  output logic              stall_req_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [7:0]        mem_wdata_o,
  input  logic [7:0]        mem_rdata_i,
  input  logic              mem_ack_i,
`ifdef MEM_ALIGN_CHECK_EN
  output logic              misalign_o,
`endif
  output state_t            fsm_state
);

  // RAM handshake: mem_req_o is valid and holds addr/we/wdata stable until
  // the cycle mem_ack_i is high; that cycle completes exactly one byte.

  state_t             state_q, state_d;
  alu_op_bus_t        op_q;
  logic [ADDR_W-1:0]  addr_q;
  reg_bus_t           data_q;
  reg_addr_bus_t      wd_q;
  logic               wreg_q;
  logic [1:0]         cnt_q;
  logic               mis_now, mis_q;
  logic               start;
  reg_bus_t           load_value;

  assign start     = (state_q == ST_IDLE) && is_mem(aluop_i);
  assign fsm_state = state_q;

`ifdef MEM_ALIGN_CHECK_EN
  assign mis_now = misaligned(aluop_i, mem_addr_i[1:0]);
`else
  assign mis_now = 1'b0;
  assign mis_q   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) state_q <= ST_IDLE;
    else                   state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = mis_now ? ST_DONE : ST_ACCESS;
      ST_ACCESS: if (mem_ack_i && (cnt_q == last_byte(op_q))) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      op_q   <= ME_NOP_OP;
      addr_q <= '0;
      data_q <= ZERO_WORD;
      wd_q   <= '0;
      wreg_q <= 1'b0;
      cnt_q  <= 2'd0;
    end else if (start) begin
      op_q   <= aluop_i;
      addr_q <= mem_addr_i[ADDR_W-1:0];
      data_q <= wdata_i;
      wd_q   <= wd_i;
      wreg_q <= wreg_i;
      cnt_q  <= 2'd0;
    end else if ((state_q == ST_ACCESS) && mem_ack_i) begin
      if (is_load(op_q)) data_q[{cnt_q, 3'b000} +: 8] <= mem_rdata_i;
      cnt_q <= cnt_q + 2'd1;
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) mis_q <= 1'b0;
    else if (start)        mis_q <= mis_now;
  end
`endif

  mem_load_ext u_load_ext (
    .bytes (data_q),
    .op    (op_q),
    .value (load_value)
  );

  // Outputs are forced low while reset is asserted, including the
  // combinational pass-through path.
  always_comb begin
    wd_o        = '0;
    wreg_o      = 1'b0;
    wdata_o     = ZERO_WORD;
    stall_req_o = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = 8'h00;
`ifdef MEM_ALIGN_CHECK_EN
    misalign_o  = 1'b0;
`endif
    if (rst != RST_ENABLE) begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            stall_req_o = 1'b1;
          end else begin
            wd_o    = wd_i;
            wreg_o  = wreg_i;
            wdata_o = wdata_i;
          end
        end
        ST_ACCESS: begin
          stall_req_o = 1'b1;
          mem_req_o   = 1'b1;
          mem_we_o    = is_store(op_q);
          mem_addr_o  = addr_q + ADDR_W'(cnt_q);
          if (is_store(op_q)) mem_wdata_o = data_q[{cnt_q, 3'b000} +: 8];
        end
        ST_DONE: begin
          wd_o    = wd_q;
          wreg_o  = is_load(op_q) && wreg_q && (wd_q != 5'd0) && !mis_q;
          wdata_o = (is_load(op_q) && !mis_q) ? load_value : ZERO_WORD;
`ifdef MEM_ALIGN_CHECK_EN
          misalign_o = mis_q;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: reset, pass-through, loads, stores, wait
// states, address wrap and back-to-back accesses against hand-computed values.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  reg_addr_bus_t wd_i;
  logic          wreg_i;
  reg_bus_t      wdata_i;
  alu_op_bus_t   aluop_i;
  reg_bus_t      mem_addr_i;
  reg_addr_bus_t wd_o;
  logic          wreg_o;
  reg_bus_t      wdata_o;
  logic          stall_req_o;
  logic          mem_req_o;
  logic          mem_we_o;
  logic [31:0]   mem_addr_o;
  logic [7:0]    mem_wdata_o;
  logic [7:0]    mem_rdata_i;
  logic          mem_ack_i;
`ifdef MEM_ALIGN_CHECK_EN
  logic          misalign_o;
`endif
  state_t        fsm_state;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  mem_stage #(.ADDR_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .wd_i        (wd_i),
    .wreg_i      (wreg_i),
    .wdata_i     (wdata_i),
    .aluop_i     (aluop_i),
    .mem_addr_i  (mem_addr_i),
    .wd_o        (wd_o),
    .wreg_o      (wreg_o),
    .wdata_o     (wdata_o),
    .stall_req_o (stall_req_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i),
    .mem_ack_i   (mem_ack_i),
`ifdef MEM_ALIGN_CHECK_EN
    .misalign_o  (misalign_o),
`endif
    .fsm_state   (fsm_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One memory op from its IDLE cycle through DONE. wait_n no-ack cycles
  // are inserted before the ack of byte wait_byte.
  task automatic do_mem(input alu_op_bus_t op, input logic [31:0] addr,
                        input logic [31:0] sdata, input logic [4:0] wd,
                        input logic wreg, input int n, input logic [31:0] rbytes,
                        input int wait_byte, input int wait_n,
                        input logic [31:0] exp_wdata, input logic exp_wreg);
    int stalls;
    logic st;
    logic [31:0] a;
    stalls = 0;
    st = (op == ME_SB) || (op == ME_SH) || (op == ME_SW);
    next_cycle();
    aluop_i = op; mem_addr_i = addr; wdata_i = sdata; wd_i = wd; wreg_i = wreg;
    mem_ack_i = 1'b0;
    @(negedge clk);
    chk("idle_stall", 32'(stall_req_o), 32'd1);
    chk("idle_wreg", 32'(wreg_o), 32'd0);
    chk("idle_req", 32'(mem_req_o), 32'd0);
    stalls += int'(stall_req_o);
    for (int b = 0; b < n; b++) begin
      int w;
      w = (b == wait_byte) ? wait_n : 0;
      a = addr + 32'(b);
      for (int k = 0; k <= w; k++) begin
        next_cycle();
        mem_ack_i   = (k == w);
        mem_rdata_i = rbytes[8*b +: 8];
        @(negedge clk);
        chk("acc_req", 32'(mem_req_o), 32'd1);
        chk("acc_addr", mem_addr_o, a);
        chk("acc_we", 32'(mem_we_o), 32'(st));
        chk("acc_wreg", 32'(wreg_o), 32'd0);
        if (st) chk("acc_wdata", 32'(mem_wdata_o), 32'(sdata[8*b +: 8]));
        stalls += int'(stall_req_o);
      end
    end
    next_cycle();
    mem_ack_i = 1'b0;
    @(negedge clk);
    chk("done_stall", 32'(stall_req_o), 32'd0);
    chk("done_req", 32'(mem_req_o), 32'd0);
    chk("done_wd", 32'(wd_o), 32'(wd));
    chk("done_wreg", 32'(wreg_o), 32'(exp_wreg));
    chk("done_wdata", wdata_o, exp_wdata);
    chk("stall_cycles", 32'(stalls), 32'(n + 1 + wait_n));
  endtask

  initial begin
    rst = 1'b0;
    wd_i = 5'd5; wreg_i = 1'b1; wdata_i = 32'h1234; aluop_i = ME_NOP_OP;
    mem_addr_i = 32'h0; mem_rdata_i = 8'h00; mem_ack_i = 1'b0;

    // Reset holds all outputs low even with live pass-through inputs.
    @(negedge clk);
    chk("rst_wd", 32'(wd_o), 32'd0);
    chk("rst_wreg", 32'(wreg_o), 32'd0);
    chk("rst_wdata", wdata_o, 32'd0);
    chk("rst_state", 32'(fsm_state), 32'(ST_IDLE));
    @(negedge clk);
    rst = 1'b1;

    // Pass-through, with a stray ack that must be ignored.
    next_cycle();
    aluop_i = ME_NOP_OP; wd_i = 5'd5; wreg_i = 1'b1; wdata_i = 32'h1234; mem_ack_i = 1'b1;
    @(negedge clk);
    chk("pt_wd", 32'(wd_o), 32'd5);
    chk("pt_wreg", 32'(wreg_o), 32'd1);
    chk("pt_wdata", wdata_o, 32'h1234);
    chk("pt_stall", 32'(stall_req_o), 32'd0);
    chk("pt_req", 32'(mem_req_o), 32'd0);
    next_cycle();
    mem_ack_i = 1'b0;
    @(negedge clk);
    chk("pt_state", 32'(fsm_state), 32'(ST_IDLE));
    chk("pt_req2", 32'(mem_req_o), 32'd0);

    // LW at 0x100, byte 1 acked after 2 wait cycles.
    do_mem(ME_LW, 32'h100, 32'h0, 5'd7, 1'b1, 4, 32'h12345678, 1, 2, 32'h12345678, 1'b1);

    // Load extension.
    do_mem(ME_LB,  32'h203, 32'h0, 5'd8, 1'b1, 1, 32'h00000080, 0, 0, 32'hFFFFFF80, 1'b1);
    do_mem(ME_LBU, 32'h203, 32'h0, 5'd8, 1'b1, 1, 32'h00000080, 0, 0, 32'h00000080, 1'b1);
    do_mem(ME_LH,  32'h010, 32'h0, 5'd9, 1'b1, 2, 32'h0000F001, 0, 1, 32'hFFFFF001, 1'b1);

    // SH of 0xDEADBEEF at 0x3FF crosses into 0x400; next op requests nothing.
    do_mem(ME_SH, 32'h3FF, 32'hDEADBEEF, 5'd10, 1'b1, 2, 32'h0, 0, 0, 32'h0, 1'b0);
    next_cycle();
    aluop_i = ME_NOP_OP;
    @(negedge clk);
    chk("sh_after_req", 32'(mem_req_o), 32'd0);
    chk("sh_after_stall", 32'(stall_req_o), 32'd0);
    chk("sh_after_state", 32'(fsm_state), 32'(ST_IDLE));

    // Address wrap, wd = 0 load, then SB back-to-back.
    do_mem(ME_LW, 32'hFFFFFFFE, 32'h0, 5'd11, 1'b1, 4, 32'h44332211, 0, 0, 32'h44332211, 1'b1);
    do_mem(ME_LW, 32'h040, 32'h0, 5'd0, 1'b1, 4, 32'hCAFEF00D, 3, 1, 32'hCAFEF00D, 1'b0);
    do_mem(ME_SB, 32'h020, 32'h000000A5, 5'd12, 1'b1, 1, 32'h0, 0, 0, 32'h0, 1'b0);

    // Reset asserted mid-ACCESS of an LW.
    next_cycle();
    aluop_i = ME_LW; mem_addr_i = 32'h500; wd_i = 5'd3; wreg_i = 1'b1; mem_ack_i = 1'b0;
    next_cycle();
    @(negedge clk);
    chk("mid_req_before", 32'(mem_req_o), 32'd1);
    #1 rst = 1'b0;
    #1;
    chk("mid_rst_req", 32'(mem_req_o), 32'd0);
    chk("mid_rst_stall", 32'(stall_req_o), 32'd0);
    chk("mid_rst_state", 32'(fsm_state), 32'(ST_IDLE));
    aluop_i = ME_NOP_OP;
    @(negedge clk);
    rst = 1'b1;
    do_mem(ME_LB, 32'h203, 32'h0, 5'd4, 1'b1, 1, 32'h0000007F, 0, 0, 32'h0000007F, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM stage of the 5-stage RV32I pipeline, directly downstream of EX through the EX/MEM latch.
- Non-memory results pass through unchanged to MEM/WB.
- Loads and stores are carried out over a byte-serial, little-endian RAM port, one byte per request/ack.
- stall_req_o holds the pipeline for the whole access.

Parameters:
- ADDR_W, 32, width of mem_addr_o; the effective address is truncated to its low ADDR_W bits.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous reset, active-low
- wd_i  in  5  destination register
- wreg_i  in  1  writeback enable
- wdata_i  in  32  EX result; for stores, the store data
- aluop_i  in  8  ME_* op (ME_NOP_OP for non-memory instructions)
- mem_addr_i  in  32  effective address from EX
- wd_o  out  5  to MEM/WB
- wreg_o  out  1  to MEM/WB
- wdata_o  out  32  to MEM/WB
- stall_req_o  out  1  pipeline hold request
- mem_req_o  out  1  byte request valid
- mem_we_o  out  1  1 = write byte
- mem_addr_o  out  ADDR_W  byte address
- mem_wdata_o  out  8  write byte
- mem_rdata_i  in  8  read byte, valid when mem_ack_i = 1
- mem_ack_i  in  1  request accepted/completed this cycle

Behaviour:
- Reset: one clock (clk); reset rst is asynchronous, active-low.
  - State goes to IDLE, byte counter to 0, latches to 0.
  - All outputs are 0 while rst = 0.
  - Reset mid-access drops mem_req_o immediately and discards the access.
- Ops and byte count N:
  - ME_LB/ME_LBU/ME_SB: N = 1
  - ME_LH/ME_LHU/ME_SH: N = 2
  - ME_LW/ME_SW: N = 4
- Non-memory op (ME_NOP_OP) in IDLE:
  - wd_o/wreg_o/wdata_o equal the inputs combinationally.
  - stall_req_o = 0; zero added latency.
- FSM states: IDLE, ACCESS, DONE.
- IDLE with a memory op:
  - Latch op, address, store data, wd, wreg; counter = 0.
  - stall_req_o = 1; wreg_o = 0.
  - Next state: ACCESS.
- ACCESS:
  - mem_req_o = 1.
  - mem_addr_o = latched address + counter.
  - mem_we_o = 1 for stores.
  - mem_wdata_o = store data byte[counter].
  - stall_req_o = 1; wreg_o = 0.
  - On mem_ack_i: loads capture mem_rdata_i into byte[counter]; counter increments.
  - Ack on counter = N-1: go to DONE.
  - No ack: hold all request signals stable, with no limit on wait cycles.
- DONE:
  - stall_req_o = 0.
  - wd_o/wreg_o equal the latched values.
  - Loads: wdata_o = assembled value, sign-extended (LB/LH) or zero-extended (LBU/LHU/LW).
  - Stores: wreg_o = 0, wdata_o = 0.
  - Next state: IDLE unconditionally. The op still on the inputs in this cycle is the completed one and is never reissued.
- Latency: memory op with ack every cycle takes 1 + N + 1 cycles; stall_req_o is high for N + 1 of them.
- Address wrap: latched address + counter wraps modulo 2^ADDR_W.
- Load with wd = 0: the access is performed, but wreg_o = 0 in DONE.
- mem_ack_i outside ACCESS is ignored.

Optional Feature:
- Macro MEM_ALIGN_CHECK_EN.
- Defined:
  - Adds output misalign_o (1 bit).
  - A halfword with addr[0] = 1, or a word with addr[1:0] != 0, goes IDLE -> DONE directly with no memory request.
  - In DONE: misalign_o = 1, wreg_o = 0, wdata_o = 0; 2 cycles total.
- Undefined:
  - Misaligned accesses are served byte-serially like any other.
  - The port and its logic are absent.

Decomposition:
- Shared defines package holds:
  - ME_* op encodings (8-bit, including ME_NOP_OP)
  - AluOpBus, RegBus, RegAddrBus, ZeroWord
  - RstEnable redefined as 1'b0 for this block
  - FSM state encoding
- One sub-module: mem_load_ext, combinational.
  - Inputs: 4 captured bytes and the op.
  - Output: the 32-bit sign/zero-extended load value.

Test Plan:
- Reset: drive rst = 0 mid-ACCESS of an LW -> mem_req_o = 0 and stall_req_o = 0 immediately; after release, IDLE, with the next op starting fresh.
- Pass-through: ME_NOP_OP, wd = 5, wreg = 1, wdata = 0x1234 -> same values out the same cycle, stall_req_o = 0, mem_req_o never set.
- Load word with wait states: LW at 0x100, ack delayed 2 cycles on byte 1, bytes 0x78/0x56/0x34/0x12 -> addresses 0x100..0x103 in order, stall high 7 cycles, DONE wdata_o = 0x12345678, wreg_o = 1.
- Load extension: LB and LBU at 0x203 with byte 0x80 -> 0xFFFFFF80 and 0x00000080; LH at 0x10 with bytes 0x01/0xF0 -> 0xFFFFF001.
- Store halfword: SH of 0xDEADBEEF at 0x3FF -> writes 0xEF@0x3FF, then 0xBE@0x400, mem_we_o = 1, wreg_o = 0 throughout; next op issues no extra request.
- Back-to-back, plus wd = 0 and wrap: LW at 0xFFFFFFFE -> addresses 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1; LW with wd = 0 -> access done, wreg_o = 0; immediately followed by SB -> SB starts the cycle after DONE.
